bypass_rr_arbiter: RTL and testbench

- Round-robin arbiter and output merger for N bypass-FIFO requesters.
- Each requester raises a request. Its granted word appears on its data output one cycle after the grant.
- The arbiter issues one grant per cycle at most, captures the selected word one cycle later, and queues it in a small output buffer with a valid/ready interface toward the consumer.
- Grants are credit-limited, so the output buffer can never overflow.

---
 rtl/bypass_rr_arbiter.sv | 133 +++++++++++++
 tb/tb_bypass_rr_arbiter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/bypass_rr_arbiter.sv
// Round-robin arbiter for N bypass-FIFO requesters with a credit-limited
// output buffer; granted words are captured one cycle after the grant.
module bypass_rr_arbiter #(
    parameter int N         = 3,
    parameter int WIDTH     = 64,
    parameter int OUT_DEPTH = 4
) (
    input  logic                 CLK,
    input  logic                 Reset,
    input  logic [N-1:0]         i_Req,
    output logic [N-1:0]         o_Gnt,
    input  logic [N*WIDTH-1:0]   i_Data,
    output logic                 o_Valid,
    output logic [WIDTH-1:0]     o_Data,
    output logic [$clog2(N)-1:0] o_Src,
    input  logic                 i_Ready,
    output logic                 o_Busy
);
    localparam int SW  = $clog2(N);
    localparam int AW  = $clog2(OUT_DEPTH);
    localparam int CW  = $clog2(OUT_DEPTH + 1);
    localparam int CW1 = CW + 1;

    logic [SW-1:0]    ptr_r;
    logic             inflight_r;
    logic [SW-1:0]    sel_r;
    logic [CW-1:0]    count_r;
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [WIDTH-1:0] data_mem_r [OUT_DEPTH];
    logic [SW-1:0]    src_mem_r  [OUT_DEPTH];

    logic             grant_ok_s;
    logic             gnt_any_s;
    logic [SW-1:0]    gnt_idx_s;
    logic [SW-1:0]    scan_idx_s;
    logic             cap_s;
    logic             pop_s;
    logic [WIDTH-1:0] cap_word_s;
    logic [CW-1:0]    count_nxt_s;
    logic [AW-1:0]    rd_nxt_s;
    logic [AW-1:0]    wr_nxt_s;
    logic [WIDTH-1:0] head_data_nxt_s;
    logic [SW-1:0]    head_src_nxt_s;

    function automatic logic [SW-1:0] wrap_inc(input logic [SW-1:0] k);
        if (k == SW'(N - 1)) begin
            return SW'(0);
        end else begin
            return k + SW'(1);
        end
    endfunction

    // Credit check and rotating-priority scan starting at ptr_r.
    always_comb begin
        gnt_any_s  = 1'b0;
        gnt_idx_s  = '0;
        scan_idx_s = ptr_r;
        grant_ok_s = ({1'b0, count_r} + {{CW{1'b0}}, inflight_r}) < CW1'(OUT_DEPTH);
        if (!Reset && grant_ok_s) begin
            for (int i = 0; i < N; i++) begin
                if (!gnt_any_s && i_Req[scan_idx_s]) begin
                    gnt_any_s = 1'b1;
                    gnt_idx_s = scan_idx_s;
                end else begin
                end
                scan_idx_s = wrap_inc(scan_idx_s);
            end
        end else begin
        end
        o_Gnt = gnt_any_s ? (N'(1) << gnt_idx_s) : '0;
    end

    // Buffer bookkeeping and the head word as it will look after this edge.
    always_comb begin
        cap_s      = inflight_r;
        pop_s      = o_Valid && i_Ready;
        cap_word_s = i_Data[sel_r*WIDTH +: WIDTH];
        rd_nxt_s   = pop_s ? rd_ptr_r + AW'(1) : rd_ptr_r;
        wr_nxt_s   = cap_s ? wr_ptr_r + AW'(1) : wr_ptr_r;
        case ({cap_s, pop_s})
            2'b10:   count_nxt_s = count_r + CW'(1);
            2'b01:   count_nxt_s = count_r - CW'(1);
            default: count_nxt_s = count_r;
        endcase
        // A word captured this edge can already be the head (buffer empty after pop).
        if (cap_s && (wr_ptr_r == rd_nxt_s)) begin
            head_data_nxt_s = cap_word_s;
            head_src_nxt_s  = sel_r;
        end else begin
            head_data_nxt_s = data_mem_r[rd_nxt_s];
            head_src_nxt_s  = src_mem_r[rd_nxt_s];
        end
    end

    // Control state and registered consumer-side outputs.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            ptr_r      <= '0;
            inflight_r <= 1'b0;
            sel_r      <= '0;
            count_r    <= '0;
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            o_Valid    <= 1'b0;
            o_Data     <= '0;
            o_Src      <= '0;
            o_Busy     <= 1'b0;
        end else begin
            if (gnt_any_s) begin
                ptr_r <= wrap_inc(gnt_idx_s);
            end
            inflight_r <= gnt_any_s;
            sel_r      <= gnt_idx_s;
            count_r    <= count_nxt_s;
            wr_ptr_r   <= wr_nxt_s;
            rd_ptr_r   <= rd_nxt_s;
            o_Valid    <= (count_nxt_s != CW'(0));
            o_Data     <= head_data_nxt_s;
            o_Src      <= head_src_nxt_s;
            o_Busy     <= (count_nxt_s != CW'(0)) || gnt_any_s;
        end
    end

    // Buffer storage; contents need no reset since count gates their use.
    always_ff @(posedge CLK) begin
        if (!Reset && cap_s) begin
            data_mem_r[wr_ptr_r] <= cap_word_s;
            src_mem_r[wr_ptr_r]  <= sel_r;
        end
    end

endmodule

// File: tb/tb_bypass_rr_arbiter.sv
// Directed and random checks of bypass_rr_arbiter against a cycle model
// of grant order, credit limit and buffered word order.
module tb_bypass_rr_arbiter;
    localparam int N     = 3;
    localparam int WIDTH = 64;
    localparam int DEPTH = 4;
    localparam int SW    = 2;

    logic               CLK = 1'b0;
    logic               Reset;
    logic [N-1:0]       i_Req;
    logic [N-1:0]       o_Gnt;
    logic [N*WIDTH-1:0] i_Data;
    logic               o_Valid;
    logic [WIDTH-1:0]   o_Data;
    logic [SW-1:0]      o_Src;
    logic               i_Ready;
    logic               o_Busy;

    int checks = 0;
    int errors = 0;
    int m_ptr, m_count, m_inflight;
    int gcnt[N];
    int waitc[N];
    int n0;
    logic [SW+WIDTH-1:0] exp_q[$];

    bypass_rr_arbiter #(.N(N), .WIDTH(WIDTH), .OUT_DEPTH(DEPTH)) dut (
        .CLK(CLK), .Reset(Reset), .i_Req(i_Req), .o_Gnt(o_Gnt), .i_Data(i_Data),
        .o_Valid(o_Valid), .o_Data(o_Data), .o_Src(o_Src), .i_Ready(i_Ready),
        .o_Busy(o_Busy)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] word(input int k, input int n);
        return (64'(k) << 12) | 64'(n);
    endfunction

    // One clock: check outputs at negedge against the model, then advance it.
    task automatic tick();
        int g;
        int gi;
        logic [N-1:0] eg;
        logic pop;
        @(negedge CLK);
        g  = -1;
        gi = -1;
        eg = '0;
        if (!Reset && (m_count + m_inflight < DEPTH)) begin
            for (int i = 0; i < N; i++) begin
                int k;
                k = (m_ptr + i) % N;
                if (g < 0 && i_Req[k]) g = k;
            end
        end
        if (g >= 0) eg[g] = 1'b1;
        check("gnt", 64'(o_Gnt), 64'(eg));
        check("valid", 64'(o_Valid), 64'(m_count != 0));
        check("busy", 64'(o_Busy), 64'(m_count != 0 || m_inflight != 0));
        if (m_count != 0) begin
            check("src", 64'(o_Src), 64'(exp_q[0][WIDTH +: SW]));
            check("data", o_Data, exp_q[0][WIDTH-1:0]);
        end
        for (int k = 0; k < N; k++) if (o_Gnt[k]) gi = k;
        for (int k = 0; k < N; k++) begin
            if (!Reset && i_Req[k] && gi >= 0) begin
                if (gi == k) begin
                    waitc[k] = 0;
                end else begin
                    waitc[k]++;
                    check("fair", 64'(waitc[k] < N), 64'(1));
                end
            end else if (!i_Req[k] || Reset) begin
                waitc[k] = 0;
            end
        end
        pop = (m_count != 0) && i_Ready;
        @(posedge CLK);
        #1;
        if (Reset) begin
            m_ptr = 0; m_count = 0; m_inflight = 0;
            exp_q.delete();
        end else begin
            if (pop) void'(exp_q.pop_front());
            m_count    = m_count + m_inflight - (pop ? 1 : 0);
            m_inflight = (g >= 0) ? 1 : 0;
            if (g >= 0) begin
                exp_q.push_back({SW'(g), word(g, gcnt[g])});
                i_Data[g*WIDTH +: WIDTH] = word(g, gcnt[g]);
                gcnt[g]++;
                m_ptr = (g + 1) % N;
            end
        end
    endtask

    task automatic reset_dut();
        Reset = 1'b1;
        i_Req = '0;
        tick();
        Reset = 1'b0;
    endtask

    initial begin
        Reset = 1'b1; i_Req = '0; i_Ready = 1'b0; i_Data = '0;
        m_ptr = 0; m_count = 0; m_inflight = 0;
        for (int k = 0; k < N; k++) begin gcnt[k] = 0; waitc[k] = 0; end
        tick();
        check("rst_valid", 64'(o_Valid), 64'(0));
        check("rst_src", 64'(o_Src), 64'(0));
        check("rst_busy", 64'(o_Busy), 64'(0));

        // Single requester streams 0x1000, 0x1001, ... without gaps
        Reset = 1'b0; i_Req = 3'b010; i_Ready = 1'b1;
        #1 check("t1_gnt", 64'(o_Gnt), 64'(3'b010));
        repeat (3) tick();
        check("t1_valid", 64'(o_Valid), 64'(1));
        check("t1_src", 64'(o_Src), 64'(1));
        check("t1_data", o_Data, 64'h1001);
        repeat (5) tick();

        // All request: rotation 001, 010, 100
        reset_dut();
        i_Req = 3'b111; i_Ready = 1'b1;
        #1 check("t2_g0", 64'(o_Gnt), 64'(3'b001));
        tick();
        check("t2_g1", 64'(o_Gnt), 64'(3'b010));
        tick();
        check("t2_g2", 64'(o_Gnt), 64'(3'b100));
        repeat (6) tick();

        // Skip-over with ptr = 1
        reset_dut();
        i_Req = 3'b001; i_Ready = 1'b1;
        tick();
        i_Req = 3'b101;
        #1 check("t3_g0", 64'(o_Gnt), 64'(3'b100));
        tick();
        check("t3_g1", 64'(o_Gnt), 64'(3'b001));
        repeat (6) tick();

        // Back-pressure: four credits, then one pop frees one grant
        reset_dut();
        n0 = gcnt[0];
        i_Req = 3'b111; i_Ready = 1'b0;
        repeat (6) tick();
        check("bp_gnt", 64'(o_Gnt), 64'(0));
        check("bp_valid", 64'(o_Valid), 64'(1));
        check("bp_data", o_Data, word(0, n0));
        i_Ready = 1'b1;
        tick();
        i_Ready = 1'b0;
        #1 check("bp_regrant", 64'(o_Gnt), 64'(3'b010));
        repeat (3) tick();
        i_Ready = 1'b1;
        repeat (8) tick();

        // Reset with count 3 and a word in flight
        reset_dut();
        i_Req = 3'b111; i_Ready = 1'b0;
        repeat (4) tick();
        Reset = 1'b1;
        #1 check("mr_gnt", 64'(o_Gnt), 64'(0));
        tick();
        Reset = 1'b0;
        check("mr_valid", 64'(o_Valid), 64'(0));
        check("mr_busy", 64'(o_Busy), 64'(0));
        #1 check("mr_first", 64'(o_Gnt), 64'(3'b001));
        i_Ready = 1'b1;
        repeat (6) tick();

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            i_Req   = 3'($urandom | $urandom);
            i_Ready = 1'($urandom_range(0, 1));
            tick();
        end
        i_Req = '0; i_Ready = 1'b1;
        repeat (8) tick();
        check("drain_busy", 64'(o_Busy), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
